// File: rtl/flash_sample_reader_pkg.sv
// Shared types and helpers for the flash sample reader: FSM state encoding
// and lane-count arithmetic.
package flash_reader_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    WAIT_DATA = 2'd2,
    EMIT      = 2'd3
  } state_t;

  function automatic int lane_count(input int data_w, input int sample_w);
    return data_w / sample_w;
  endfunction

  function automatic int lane_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flash_sample_reader_if.sv
// Avalon-MM read port between the sample reader (master) and the flash
// controller (slave).
interface flash_sample_reader_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  // A read is accepted on the first rising edge where flash_mem_read=1 and
  // flash_mem_waitrequest=0; address and read hold steady until then.
  // flash_mem_readdatavalid later qualifies flash_mem_readdata for one cycle.
  logic [ADDR_W-1:0] flash_mem_address;
  logic              flash_mem_read;
  logic              flash_mem_waitrequest;
  logic [DATA_W-1:0] flash_mem_readdata;
  logic              flash_mem_readdatavalid;

  modport master (
    output flash_mem_address,
    output flash_mem_read,
    input  flash_mem_waitrequest,
    input  flash_mem_readdata,
    input  flash_mem_readdatavalid
  );

  modport slave (
    input  flash_mem_address,
    input  flash_mem_read,
    output flash_mem_waitrequest,
    output flash_mem_readdata,
    output flash_mem_readdatavalid
  );
endinterface

// File: rtl/flash_word_fetch.sv
// Single-outstanding Avalon-MM word read: holds read/address through
// waitrequest, then forwards the returned word for exactly one cycle.
module flash_word_fetch #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  flash_sample_reader_if.master bus,
  output logic                o_accept,
  output logic [DATA_W-1:0]   o_word,
  output logic                o_word_valid
);

  logic              r_read;
  logic              r_wait;
  logic [ADDR_W-1:0] r_addr;

  // r_wait is cleared by reset, so a readdatavalid belonging to an abandoned
  // read never reaches the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_read <= 1'b0;
      r_wait <= 1'b0;
      r_addr <= '0;
    end else begin
      if (r_read) begin
        if (!bus.flash_mem_waitrequest) begin
          r_read <= 1'b0;
          r_wait <= 1'b1;
        end
      end else if (i_req && !r_wait) begin
        r_read <= 1'b1;
        r_addr <= i_addr;
      end
      if (r_wait && bus.flash_mem_readdatavalid) begin
        r_wait <= 1'b0;
      end
    end
  end

  assign bus.flash_mem_read    = r_read;
  assign bus.flash_mem_address = r_addr;
  assign o_accept              = r_read && !bus.flash_mem_waitrequest;
  assign o_word                = bus.flash_mem_readdata;
  assign o_word_valid          = r_wait && bus.flash_mem_readdatavalid;

endmodule

// File: rtl/flash_sample_reader.sv
// Buffers one flash word and hands out SAMPLE_W-wide lanes one per request,
// stepping forward or backward through word addresses 0..END_ADDR.
module flash_sample_reader
  import flash_reader_pkg::*;
#(
  parameter int                ADDR_W   = 23,
  parameter int                DATA_W   = 32,
  parameter int                SAMPLE_W = 16,
  parameter logic [ADDR_W-1:0] END_ADDR = ADDR_W'(23'h7FFFF)
) (
  input  logic                  clk50M,
  input  logic                  reset,
  input  logic                  start_read_flag,
  input  logic                  direction,
  input  logic                  loop_en,
  input  logic                  restart,
  flash_sample_reader_if.master flash_if,
  output logic [SAMPLE_W-1:0]   sample_out,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  done,
  output state_t                o_dbg_state
);

  localparam int                N         = lane_count(DATA_W, SAMPLE_W);
  localparam int                LANE_W    = lane_idx_w(N);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LANE_W-1:0]   r_lane;
  logic [DATA_W-1:0]   r_buf;
  logic                r_buf_valid;
  logic [SAMPLE_W-1:0] r_sample;
  logic                r_sample_valid;
  logic                r_busy;
  logic                r_done;
  logic                r_dir;
  logic                r_rst_pend;
  logic                r_rst_dir;

  logic                w_fetch_req;
  logic                w_accept;
  logic [DATA_W-1:0]   w_word;
  logic                w_word_valid;
  logic [SAMPLE_W-1:0] w_lanes [N];
  logic                w_home_dir;
  logic [ADDR_W-1:0]   w_home_addr;
  logic [LANE_W-1:0]   w_home_lane;
  logic [ADDR_W-1:0]   w_adv_addr;
  logic [LANE_W-1:0]   w_adv_lane;
  logic                w_adv_keep;
  logic                w_adv_done;

  for (genvar k = 0; k < N; k++) begin : g_lane
    assign w_lanes[k] = r_buf[k*SAMPLE_W +: SAMPLE_W];
  end

  assign w_fetch_req = (r_state == IDLE) && !restart && start_read_flag &&
                       !r_done && !r_buf_valid;

  flash_word_fetch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fetch (
    .clk          (clk50M),
    .rst          (reset),
    .i_req        (w_fetch_req),
    .i_addr       (r_addr),
    .bus          (flash_if),
    .o_accept     (w_accept),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // A restart latched while busy keeps the direction seen at that moment.
  always_comb begin
    w_home_dir  = (r_state == EMIT && r_rst_pend) ? r_rst_dir : direction;
    w_home_addr = w_home_dir ? END_ADDR : '0;
    w_home_lane = w_home_dir ? LAST_LANE : '0;
  end

  // Next position after emitting; w_adv_keep says the buffered word still applies.
  always_comb begin
    w_adv_addr = r_addr;
    w_adv_lane = r_lane;
    w_adv_keep = 1'b1;
    w_adv_done = 1'b0;
    if (!r_dir) begin
      if (r_lane != LAST_LANE) begin
        w_adv_lane = r_lane + LANE_W'(1);
      end else begin
        w_adv_keep = 1'b0;
        if (r_addr != END_ADDR) begin
          w_adv_lane = '0;
          w_adv_addr = r_addr + ADDR_W'(1);
        end else if (loop_en) begin
          w_adv_lane = '0;
          w_adv_addr = '0;
        end else begin
          w_adv_done = 1'b1;
        end
      end
    end else begin
      if (r_lane != '0) begin
        w_adv_lane = r_lane - LANE_W'(1);
      end else begin
        w_adv_keep = 1'b0;
        if (r_addr != '0) begin
          w_adv_lane = LAST_LANE;
          w_adv_addr = r_addr - ADDR_W'(1);
        end else if (loop_en) begin
          w_adv_lane = LAST_LANE;
          w_adv_addr = END_ADDR;
        end else begin
          w_adv_done = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk50M) begin
    if (reset) begin
      r_state        <= IDLE;
      r_addr         <= '0;
      r_lane         <= '0;
      r_buf          <= '0;
      r_buf_valid    <= 1'b0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_dir          <= 1'b0;
      r_rst_pend     <= 1'b0;
      r_rst_dir      <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (restart) begin
            r_addr      <= w_home_addr;
            r_lane      <= w_home_lane;
            r_buf_valid <= 1'b0;
            r_done      <= 1'b0;
          end else if (start_read_flag && !r_done) begin
            r_busy  <= 1'b1;
            r_dir   <= direction;
            r_state <= r_buf_valid ? EMIT : FETCH;
          end
        end
        FETCH: begin
          if (restart) begin
            r_rst_pend <= 1'b1;
            r_rst_dir  <= direction;
          end
          if (w_accept) begin
            r_state <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (restart) begin
            r_rst_pend <= 1'b1;
            r_rst_dir  <= direction;
          end
          if (w_word_valid) begin
            r_buf       <= w_word;
            r_buf_valid <= 1'b1;
            r_state     <= EMIT;
          end
        end
        EMIT: begin
          r_sample       <= w_lanes[r_lane];
          r_sample_valid <= 1'b1;
          r_busy         <= 1'b0;
          r_rst_pend     <= 1'b0;
          r_state        <= IDLE;
          if (r_rst_pend || restart) begin
            r_addr      <= w_home_addr;
            r_lane      <= w_home_lane;
            r_buf_valid <= 1'b0;
            r_done      <= 1'b0;
          end else begin
            r_addr <= w_adv_addr;
            r_lane <= w_adv_lane;
            if (!w_adv_keep) r_buf_valid <= 1'b0;
            if (w_adv_done)  r_done      <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sample_out   = r_sample;
  assign sample_valid = r_sample_valid;
  assign busy         = r_busy;
  assign done         = r_done;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_flash_sample_reader.sv
// Directed bench for flash_sample_reader with a two-word flash model
// (END_ADDR = 1) that has programmable waitrequest stalls.
module tb_flash_sample_reader;
  import flash_reader_pkg::*;

  localparam int HIT  = 1;
  localparam int MISS = 2;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   start_read_flag = 1'b0;
  logic   direction = 1'b0;
  logic   loop_en = 1'b0;
  logic   restart = 1'b0;
  logic [15:0] sample_out;
  logic   sample_valid;
  logic   busy;
  logic   done;
  state_t dut_state;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  flash_sample_reader_if #(.ADDR_W(23), .DATA_W(32)) bus ();

  flash_sample_reader #(
    .ADDR_W   (23),
    .DATA_W   (32),
    .SAMPLE_W (16),
    .END_ADDR (23'd1)
  ) dut (
    .clk50M          (clk),
    .reset           (reset),
    .start_read_flag (start_read_flag),
    .direction       (direction),
    .loop_en         (loop_en),
    .restart         (restart),
    .flash_if        (bus),
    .sample_out      (sample_out),
    .sample_valid    (sample_valid),
    .busy            (busy),
    .done            (done),
    .o_dbg_state     (dut_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // flash model: stall_cfg waitrequest cycles per read, data two edges after accept
  int          stall_cfg = 0;
  int          stall_cnt = 0;
  logic        s1 = 1'b0;
  logic        s2 = 1'b0;
  logic [22:0] s1_addr = '0;
  logic [22:0] s2_addr = '0;
  logic        inject_rdv = 1'b0;
  logic [22:0] acc_q[$];
  logic [31:0] mem [2];

  initial begin
    mem[0] = 32'hBBBB_AAAA;
    mem[1] = 32'hDDDD_CCCC;
  end

  assign bus.flash_mem_waitrequest   = bus.flash_mem_read && (stall_cnt < stall_cfg);
  assign bus.flash_mem_readdatavalid = s2 | inject_rdv;
  assign bus.flash_mem_readdata      = inject_rdv ? 32'h5A5A_F00D : mem[s2_addr[0]];

  always @(posedge clk) begin
    if (bus.flash_mem_read && bus.flash_mem_waitrequest) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
    s1      <= bus.flash_mem_read && !bus.flash_mem_waitrequest;
    s1_addr <= bus.flash_mem_address;
    s2      <= s1;
    s2_addr <= s1_addr;
    if (bus.flash_mem_read && !bus.flash_mem_waitrequest) acc_q.push_back(bus.flash_mem_address);
  end

  always @(negedge clk) begin
    if (sample_valid === 1'b1) vcount <= vcount + 1;
  end

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic pulse_restart();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic [15:0] exp, input int kind,
                        input logic [22:0] exp_addr, output int rd_cycles);
    bit seen;
    bit first_rd;
    bit addr_ok;
    int lat;
    seen = 0; first_rd = 0; addr_ok = 1; lat = 0; rd_cycles = 0;
    @(negedge clk); start_read_flag = 1'b1;
    @(negedge clk); start_read_flag = 1'b0;
    first_rd = bus.flash_mem_read;
    for (int i = 1; i <= 40; i++) begin
      if (sample_valid === 1'b1) begin
        seen = 1; lat = i;
        break;
      end
      if (bus.flash_mem_read === 1'b1) begin
        rd_cycles++;
        if (bus.flash_mem_address !== exp_addr) addr_ok = 0;
      end
      @(negedge clk);
    end
    chk({tag, "_valid"}, seen, 1);
    chk({tag, "_data"}, sample_out, exp);
    if (kind == HIT) begin
      chk({tag, "_hit_lat"}, lat, 2);
    end else begin
      chk({tag, "_rd_t1"}, first_rd, 1);
      chk({tag, "_rd_addr"}, addr_ok, 1);
      chk({tag, "_miss_lat"}, lat, 5 + stall_cfg);
    end
  endtask

  task automatic wait_state(input string tag, input state_t st);
    bit ok;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (dut_state == st) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_reach"}, ok, 1);
  endtask

  task automatic expect_no_sample(input string tag, input int cycles);
    int v0;
    int a0;
    v0 = vcount;
    a0 = acc_q.size();
    repeat (cycles) @(negedge clk);
    chk({tag, "_no_valid"}, vcount - v0, 0);
    chk({tag, "_no_read"}, acc_q.size() - a0, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd;
    int a0;
    int v0;

    repeat (3) @(negedge clk);
    chk("rst_addr", bus.flash_mem_address, 0);
    chk("rst_read", bus.flash_mem_read, 0);
    chk("rst_sample", sample_out, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_state", dut_state, IDLE);
    reset = 1'b0;

    // forward walk through both words, loop disabled
    do_req("fwd0", 16'hAAAA, MISS, 23'd0, rd);
    do_req("fwd1", 16'hBBBB, HIT,  23'd0, rd);
    do_req("fwd2", 16'hCCCC, MISS, 23'd1, rd);
    do_req("fwd3", 16'hDDDD, HIT,  23'd1, rd);
    chk("fwd_reads", acc_q.size(), 2);
    chk("fwd_rd0", acc_q[0], 0);
    chk("fwd_rd1", acc_q[1], 1);
    chk("fwd_done", done, 1);
    @(negedge clk); start_read_flag = 1'b1;
    @(negedge clk); start_read_flag = 1'b0;
    expect_no_sample("end_noloop", 15);
    chk("end_done_held", done, 1);

    // waitrequest stall on address 0
    pulse_restart();
    chk("restart_clr_done", done, 0);
    stall_cfg = 3;
    a0 = acc_q.size();
    v0 = vcount;
    do_req("stall", 16'hAAAA, MISS, 23'd0, rd);
    chk("stall_rd_cycles", rd, 4);
    repeat (5) @(negedge clk);
    chk("stall_accepts", acc_q.size() - a0, 1);
    chk("stall_valid_once", vcount - v0, 1);
    stall_cfg = 0;

    // reverse from END_ADDR lane 1
    direction = 1'b1;
    pulse_restart();
    a0 = acc_q.size();
    do_req("rev0", 16'hDDDD, MISS, 23'd1, rd);
    do_req("rev1", 16'hCCCC, HIT,  23'd1, rd);
    do_req("rev2", 16'hBBBB, MISS, 23'd0, rd);
    do_req("rev3", 16'hAAAA, HIT,  23'd0, rd);
    chk("rev_reads", acc_q.size() - a0, 2);
    chk("rev_rd0", acc_q[a0], 1);
    chk("rev_rd1", acc_q[a0 + 1], 0);
    chk("rev_done", done, 1);

    // forward with wrap
    direction = 1'b0;
    loop_en = 1'b1;
    pulse_restart();
    do_req("loop0", 16'hAAAA, MISS, 23'd0, rd);
    do_req("loop1", 16'hBBBB, HIT,  23'd0, rd);
    do_req("loop2", 16'hCCCC, MISS, 23'd1, rd);
    do_req("loop3", 16'hDDDD, HIT,  23'd1, rd);
    chk("loop_not_done", done, 0);
    a0 = acc_q.size();
    do_req("loop4", 16'hAAAA, MISS, 23'd0, rd);
    chk("loop_wrap_reads", acc_q.size() - a0, 1);
    chk("loop_wrap_addr", acc_q[a0], 0);

    // second start during WAIT_DATA is dropped
    pulse_restart();
    v0 = vcount;
    @(negedge clk); start_read_flag = 1'b1;
    @(negedge clk); start_read_flag = 1'b0;
    wait_state("busy_wd", WAIT_DATA);
    chk("busy_high", busy, 1);
    start_read_flag = 1'b1;
    @(negedge clk); start_read_flag = 1'b0;
    repeat (12) @(negedge clk);
    chk("busy_one_valid", vcount - v0, 1);
    chk("busy_sample", sample_out, 16'hAAAA);
    chk("busy_low", busy, 0);

    // restart and start in the same IDLE cycle: restart wins
    @(negedge clk); restart = 1'b1; start_read_flag = 1'b1;
    @(negedge clk); restart = 1'b0; start_read_flag = 1'b0;
    expect_no_sample("rs_start", 8);
    chk("rs_start_busy", busy, 0);

    // restart while busy: in-flight sample still delivered, then addr 0 again
    a0 = acc_q.size();
    v0 = vcount;
    @(negedge clk); start_read_flag = 1'b1;
    @(negedge clk); start_read_flag = 1'b0;
    wait_state("rwb_wd", WAIT_DATA);
    restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    repeat (8) @(negedge clk);
    chk("rwb_valid", vcount - v0, 1);
    chk("rwb_sample", sample_out, 16'hAAAA);
    do_req("rwb_next", 16'hAAAA, MISS, 23'd0, rd);
    chk("rwb_reads", acc_q.size() - a0, 2);
    chk("rwb_rd1", acc_q[a0 + 1], 0);

    // reset while FETCH is stalled on address 1
    direction = 1'b1;
    pulse_restart();
    stall_cfg = 20;
    @(negedge clk); start_read_flag = 1'b1;
    @(negedge clk); start_read_flag = 1'b0;
    @(negedge clk);
    chk("rf_read_hi", bus.flash_mem_read, 1);
    chk("rf_addr1", bus.flash_mem_address, 1);
    chk("rf_state", dut_state, FETCH);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("rf_read", bus.flash_mem_read, 0);
    chk("rf_addr", bus.flash_mem_address, 0);
    chk("rf_sample", sample_out, 0);
    chk("rf_valid", sample_valid, 0);
    chk("rf_busy", busy, 0);
    chk("rf_done", done, 0);
    chk("rf_idle", dut_state, IDLE);
    stall_cfg = 0;
    v0 = vcount;
    inject_rdv = 1'b1;
    @(negedge clk); inject_rdv = 1'b0;
    repeat (10) @(negedge clk);
    chk("rf_late_rdv", vcount - v0, 0);
    chk("rf_still_idle", dut_state, IDLE);
    direction = 1'b0;
    do_req("rf_after", 16'hAAAA, MISS, 23'd0, rd);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
